// File: rtl/spi_pkg.sv
// Shared SPI constants used by the TX FIFO,
// the register file and the SPI master controller.
package spi_pkg;

  localparam int SPI_DATA_W       = 32;
  localparam int SPI_TXFIFO_DEPTH = 8;

endpackage

// File: rtl/spi_fifo_mem.sv
// TX FIFO storage: DEPTH x DATA_W, one write port,
// one async read port. Ports: i_clk, i_we, i_waddr, i_wdata, i_raddr, o_rdata.
module spi_fifo_mem
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int DEPTH  = SPI_TXFIFO_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // storage is intentionally not reset
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/spi_tx_fifo.sv
// Show-ahead TX FIFO feeding the SPI master stream.
// Ports: pclk_i/prst_n_i, wr_* push side, stream_* pop side, flush/ovf/status.
module spi_tx_fifo
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int DEPTH  = SPI_TXFIFO_DEPTH,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              pclk_i,
  input  logic              prst_n_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_vld_i,
  output logic              wr_rdy_o,
  output logic [DATA_W-1:0] stream_data_o,
  output logic              stream_data_vld_o,
  input  logic              stream_data_rdy_i,
  input  logic              flush_i,
  input  logic              ovf_clr_i,
  output logic [LVL_W-1:0]  level_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              ovf_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_ovf;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_ovf_evt;

  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_push    = wr_vld_i && !w_full;
  assign w_pop     = stream_data_rdy_i && !w_empty;
  // a write against a full FIFO is rejected even if a pop frees a slot
  assign w_ovf_evt = wr_vld_i && w_full;

  spi_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .i_clk   (pclk_i),
    .i_we    (w_push && !flush_i),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data_i),
    .i_raddr (r_rd_ptr),
    .o_rdata (stream_data_o)
  );

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // sticky; a new overflow beats a clear on the same edge
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_evt) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr_i) begin
      r_ovf <= 1'b0;
    end
  end

  assign wr_rdy_o          = !w_full;
  assign stream_data_vld_o = !w_empty;
  assign level_o           = r_level;
  assign empty_o           = w_empty;
  assign full_o            = w_full;
  assign ovf_o             = r_ovf;

endmodule
